// File: rtl/e203_dtcm_ctrl_pkg.sv
// Shared types for the DTCM RAM controller: FSM states, requester index, idle counter.
package e203_dtcm_ctrl_pkg;

    localparam int unsigned IDLE_CNT_W = 8;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } dtcm_state_e;

    // 0 = core LSU, 1 = external ICB slave path
    typedef logic req_idx_t;

    typedef logic [IDLE_CNT_W-1:0] idle_cnt_t;

endpackage

// File: rtl/e203_dtcm_ram_ctrl_if.sv
// One requester's command/response channel into the DTCM RAM controller.
interface e203_dtcm_ram_ctrl_if #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 32,
    parameter int unsigned MW = 4
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/e203_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and moves on advance.
module e203_rr_arb2
    import e203_dtcm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output req_idx_t   grant_idx
);

    req_idx_t last_q;

    always_comb begin
        grant_idx = 1'b0;
        case (valid)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_q;
            default: grant_idx = 1'b0;
        endcase
        grant = (valid == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
    end

    // Resetting to 1 lets requester 0 win the first contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/e203_dtcm_ram_ctrl.sv
// Shares the single-port DTCM SRAM between LSU and ICB requesters, hides the one-cycle
// read latency behind a response handshake and manages light-sleep entry/exit.
module e203_dtcm_ram_ctrl
    import e203_dtcm_ctrl_pkg::*;
#(
    parameter int unsigned AW          = 14,
    parameter int unsigned DW          = 32,
    parameter int unsigned MW          = 4,
    parameter int unsigned IDLE_LS_CYC = 16
) (
    input  logic                clk_dtcm_ram,
    input  logic                rst_dtcm,
    e203_dtcm_ram_ctrl_if.slave req0,
    e203_dtcm_ram_ctrl_if.slave req1,
    output logic                dtcm_ram_cs,
    output logic                dtcm_ram_we,
    output logic [AW-1:0]       dtcm_ram_addr,
    output logic [MW-1:0]       dtcm_ram_wem,
    output logic [DW-1:0]       dtcm_ram_din,
    input  logic [DW-1:0]       dtcm_ram_dout,
    output logic                dtcm_ram_ls,
    output logic                dtcm_ram_ds,
    output logic                dtcm_ram_sd
);

    localparam idle_cnt_t IdleMax = idle_cnt_t'(IDLE_LS_CYC);

    dtcm_state_e   state_q;
    logic          ls_q;
    idle_cnt_t     idle_q;
    logic          rsp_pend_q;
    req_idx_t      rsp_owner_q;
    logic          rsp_is_read_q;
    logic          hold_vld_q;
    logic [DW-1:0] hold_q;
    logic [AW-1:0] addr_q;
    logic [MW-1:0] wem_q;
    logic [DW-1:0] din_q;

    logic [1:0]    arb_grant;
    req_idx_t      grant_idx;
    logic          rsp_ready_sel;
    logic          rsp_accept;
    logic          eligible;
    logic          fire;
    logic          sel_read;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [MW-1:0] sel_wmask;
    logic [DW-1:0] rsp_data;

    e203_rr_arb2 u_arb (
        .clk       (clk_dtcm_ram),
        .rst       (rst_dtcm),
        .valid     ({req1.cmd_valid, req0.cmd_valid}),
        .advance   (fire),
        .grant     (arb_grant),
        .grant_idx (grant_idx)
    );

    // A new command may issue in the same cycle the outstanding response is accepted.
    assign rsp_ready_sel = rsp_owner_q ? req1.rsp_ready : req0.rsp_ready;
    assign rsp_accept    = rsp_pend_q & rsp_ready_sel;
    assign eligible      = (state_q == ACTIVE) & (~rsp_pend_q | rsp_accept);
    assign fire          = eligible & (|arb_grant);

    assign req0.cmd_ready = eligible & arb_grant[0];
    assign req1.cmd_ready = eligible & arb_grant[1];

    always_comb begin
        sel_read  = req0.cmd_read;
        sel_addr  = req0.cmd_addr;
        sel_wdata = req0.cmd_wdata;
        sel_wmask = req0.cmd_wmask;
        if (grant_idx) begin
            sel_read  = req1.cmd_read;
            sel_addr  = req1.cmd_addr;
            sel_wdata = req1.cmd_wdata;
            sel_wmask = req1.cmd_wmask;
        end
    end

    // Address/mask/data hold their last driven values whenever no access is issued.
    always_comb begin
        dtcm_ram_cs   = fire;
        dtcm_ram_we   = fire & ~sel_read;
        dtcm_ram_addr = fire ? sel_addr : addr_q;
        dtcm_ram_wem  = fire ? (sel_read ? '0 : sel_wmask) : wem_q;
        dtcm_ram_din  = fire ? (sel_read ? '0 : sel_wdata) : din_q;
    end

    assign dtcm_ram_ls = ls_q;
    assign dtcm_ram_ds = 1'b0;
    assign dtcm_ram_sd = 1'b0;

    // The macro output is only good for one cycle; a stalled read replays from hold_q.
    assign rsp_data       = rsp_is_read_q ? (hold_vld_q ? hold_q : dtcm_ram_dout) : '0;
    assign req0.rsp_valid = rsp_pend_q & ~rsp_owner_q;
    assign req1.rsp_valid = rsp_pend_q & rsp_owner_q;
    assign req0.rsp_rdata = req0.rsp_valid ? rsp_data : '0;
    assign req1.rsp_rdata = req1.rsp_valid ? rsp_data : '0;

    always_ff @(posedge clk_dtcm_ram) begin
        if (rst_dtcm) begin
            rsp_pend_q    <= 1'b0;
            rsp_owner_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            hold_vld_q    <= 1'b0;
            hold_q        <= '0;
            addr_q        <= '0;
            wem_q         <= '0;
            din_q         <= '0;
        end else begin
            addr_q <= dtcm_ram_addr;
            wem_q  <= dtcm_ram_wem;
            din_q  <= dtcm_ram_din;
            if (fire) begin
                rsp_pend_q    <= 1'b1;
                rsp_owner_q   <= grant_idx;
                rsp_is_read_q <= sel_read;
                hold_vld_q    <= 1'b0;
            end else if (rsp_accept) begin
                rsp_pend_q <= 1'b0;
                hold_vld_q <= 1'b0;
            end else if (rsp_pend_q && rsp_is_read_q && !hold_vld_q) begin
                hold_q     <= dtcm_ram_dout;
                hold_vld_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_dtcm_ram) begin
        if (rst_dtcm) begin
            idle_q <= '0;
        end else if (fire || rsp_pend_q) begin
            idle_q <= '0;
        end else if (idle_q < IdleMax) begin
            idle_q <= idle_q + idle_cnt_t'(1);
        end
    end

    always_ff @(posedge clk_dtcm_ram) begin
        if (rst_dtcm) begin
            state_q <= ACTIVE;
            ls_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ACTIVE: begin
                    if (idle_q == IdleMax && !fire) begin
                        state_q <= SLEEP;
                        ls_q    <= 1'b1;
                    end
                end
                SLEEP: begin
                    if (req0.cmd_valid || req1.cmd_valid) begin
                        state_q <= WAKE;
                        ls_q    <= 1'b0;
                    end
                end
                WAKE: begin
                    state_q <= ACTIVE;
                end
                default: begin
                    state_q <= ACTIVE;
                    ls_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e203_dtcm_ram_ctrl.sv
// Directed bench for e203_dtcm_ram_ctrl with a behavioural single-port SRAM model.
module tb_e203_dtcm_ram_ctrl;

    localparam int unsigned AW   = 14;
    localparam int unsigned DW   = 32;
    localparam int unsigned MW   = 4;
    localparam int unsigned IDLE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    e203_dtcm_ram_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) r0 ();
    e203_dtcm_ram_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) r1 ();

    logic          cs, we, ls, ds, sd;
    logic [AW-1:0] addr;
    logic [MW-1:0] wem;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    int checks   = 0;
    int failures = 0;

    e203_dtcm_ram_ctrl #(
        .AW          (AW),
        .DW          (DW),
        .MW          (MW),
        .IDLE_LS_CYC (IDLE)
    ) dut (
        .clk_dtcm_ram  (clk),
        .rst_dtcm      (rst),
        .req0          (r0),
        .req1          (r1),
        .dtcm_ram_cs   (cs),
        .dtcm_ram_we   (we),
        .dtcm_ram_addr (addr),
        .dtcm_ram_wem  (wem),
        .dtcm_ram_din  (din),
        .dtcm_ram_dout (dout),
        .dtcm_ram_ls   (ls),
        .dtcm_ram_ds   (ds),
        .dtcm_ram_sd   (sd)
    );

    // SRAM model: dout is only meaningful the cycle after a read, garbage otherwise.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (cs && we) begin
            for (int b = 0; b < MW; b++) begin
                if (wem[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
            end
        end
        dout <= (cs && !we) ? mem[addr] : 32'h0BAD_F00D;
    end

    task automatic set_cmd(input int p, input logic v, input logic rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        if (p == 0) begin
            r0.cmd_valid = v; r0.cmd_read = rd; r0.cmd_addr = a;
            r0.cmd_wdata = wd; r0.cmd_wmask = wm;
        end else begin
            r1.cmd_valid = v; r1.cmd_read = rd; r1.cmd_addr = a;
            r1.cmd_wdata = wd; r1.cmd_wmask = wm;
        end
    endtask

    // One uncontended access with rsp_ready high; returns what was observed.
    task automatic access(input int p, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                          output logic gnt, output logic rv, output logic [DW-1:0] rdata);
        @(posedge clk); #1;
        set_cmd(p, 1'b1, rd, a, wd, wm);
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        @(negedge clk);
        gnt = (p == 0) ? r0.cmd_ready : r1.cmd_ready;
        @(posedge clk); #1;
        set_cmd(p, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rv    = (p == 0) ? r0.rsp_valid : r1.rsp_valid;
        rdata = (p == 0) ? r0.rsp_rdata : r1.rsp_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cs, we, ls, ds, sd, r0.cmd_ready, r1.cmd_ready, r0.rsp_valid, r1.rsp_valid} !== 9'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {cs, we, ls, ds, sd, r0.cmd_ready, r1.cmd_ready, r0.rsp_valid, r1.rsp_valid});
        end
        checks++;
        if (addr !== '0 || wem !== '0 || din !== '0) begin
            failures++;
            $display("FAIL reset_bus: addr=%h wem=%h din=%h required 0", addr, wem, din);
        end
        checks++;
        if (r0.rsp_rdata !== '0 || r1.rsp_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got %h/%h required 0", r0.rsp_rdata, r1.rsp_rdata);
        end
    endtask

    task automatic test_contention();
        @(posedge clk); #1;
        set_cmd(0, 1'b1, 1'b0, 14'h30, 32'h0000_AAAA, 4'hF);
        set_cmd(1, 1'b1, 1'b0, 14'h31, 32'h0000_BBBB, 4'hF);
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({r1.cmd_ready, r0.cmd_ready} !== (i[0] ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got %b required %b", i,
                         {r1.cmd_ready, r0.cmd_ready}, (i[0] ? 2'b10 : 2'b01));
            end
            checks++;
            if (cs !== 1'b1 || addr !== (i[0] ? 14'h31 : 14'h30)) begin
                failures++;
                $display("FAIL contention_cs[%0d]: cs=%b addr=%h required cs=1 addr=%h", i, cs,
                         addr, (i[0] ? 14'h31 : 14'h30));
            end
            if (i > 0) begin
                checks++;
                if ((i[0] ? r0.rsp_valid : r1.rsp_valid) !== 1'b1) begin
                    failures++;
                    $display("FAIL contention_rsp[%0d]: got 0 required 1", i);
                end
            end
            @(posedge clk); #1;
        end
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== '0 || cs !== 1'b0) begin
            failures++;
            $display("FAIL contention_tail: rsp_valid=%b rdata=%h cs=%b required 1/0/0",
                     r1.rsp_valid, r1.rsp_rdata, cs);
        end
    endtask

    task automatic test_single_read();
        logic g, v;
        logic [DW-1:0] d;
        access(0, 1'b0, 14'h10, 32'hDEAD_BEEF, 4'hF, g, v, d);
        checks++;
        if (g !== 1'b1 || v !== 1'b1 || d !== '0) begin
            failures++;
            $display("FAIL write_0x10: gnt=%b rsp=%b rdata=%h required 1/1/0", g, v, d);
        end
        access(0, 1'b1, 14'h10, '0, '0, g, v, d);
        checks++;
        if (g !== 1'b1 || v !== 1'b1) begin
            failures++;
            $display("FAIL read_0x10_hs: gnt=%b rsp=%b required 1/1", g, v);
        end
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL read_0x10_data: got %h required deadbeef", d);
        end
    endtask

    task automatic test_partial_write();
        logic g, v;
        logic [DW-1:0] d;
        access(1, 1'b0, 14'h5, 32'h1122_3344, 4'hF, g, v, d);
        access(1, 1'b0, 14'h5, 32'hAABB_CCDD, 4'b0101, g, v, d);
        checks++;
        if (g !== 1'b1 || v !== 1'b1) begin
            failures++;
            $display("FAIL partial_write_hs: gnt=%b rsp=%b required 1/1", g, v);
        end
        access(0, 1'b1, 14'h5, '0, '0, g, v, d);
        checks++;
        if (d !== 32'h11BB_33DD) begin
            failures++;
            $display("FAIL partial_read: got %h required 11bb33dd", d);
        end
    endtask

    task automatic test_backpressure();
        logic g, v;
        logic [DW-1:0] d;
        access(0, 1'b0, 14'h20, 32'hCAFE_F00D, 4'hF, g, v, d);
        @(posedge clk); #1;
        set_cmd(1, 1'b1, 1'b1, 14'h20, '0, '0);
        set_cmd(0, 1'b1, 1'b0, 14'h21, 32'h1234_5678, 4'hF);
        r1.rsp_ready = 1'b0;
        r0.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({r1.cmd_ready, r0.cmd_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_grant: got %b required 10", {r1.cmd_ready, r0.cmd_ready});
        end
        @(posedge clk); #1;
        set_cmd(1, 1'b1, 1'b1, 14'h21, '0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 32'hCAFE_F00D) begin
                failures++;
                $display("FAIL bp_stall_rsp[%0d]: valid=%b rdata=%h required 1/cafef00d", k,
                         r1.rsp_valid, r1.rsp_rdata);
            end
            checks++;
            if ({r1.cmd_ready, r0.cmd_ready, cs} !== 3'b000) begin
                failures++;
                $display("FAIL bp_stall_grant[%0d]: got %b required 000", k,
                         {r1.cmd_ready, r0.cmd_ready, cs});
            end
            @(posedge clk); #1;
        end
        r1.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL bp_hs_rsp: valid=%b rdata=%h required 1/cafef00d", r1.rsp_valid,
                     r1.rsp_rdata);
        end
        checks++;
        if ({r1.cmd_ready, r0.cmd_ready} !== 2'b01 || cs !== 1'b1 || we !== 1'b1 ||
            addr !== 14'h21) begin
            failures++;
            $display("FAIL bp_hs_grant: rdy=%b cs=%b we=%b addr=%h required 01/1/1/0021",
                     {r1.cmd_ready, r0.cmd_ready}, cs, we, addr);
        end
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== '0 || r1.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_rsp: r0 valid=%b rdata=%h r1 valid=%b required 1/0/0",
                     r0.rsp_valid, r0.rsp_rdata, r1.rsp_valid);
        end
    endtask

    task automatic test_sleep_wake();
        int  n    = 0;
        bit  seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (ls === 1'b1) begin
                seen = 1'b1;
                n    = i;
            end
        end
        checks++;
        if (!seen || n != IDLE + 2) begin
            failures++;
            $display("FAIL sleep_entry: ls seen=%0d after %0d cycles required %0d", seen, n,
                     IDLE + 2);
        end
        @(posedge clk); #1;
        set_cmd(0, 1'b1, 1'b1, 14'h10, '0, '0);
        r0.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ls, r0.cmd_ready, cs} !== 3'b100) begin
            failures++;
            $display("FAIL wake_n0: ls/rdy/cs=%b required 100", {ls, r0.cmd_ready, cs});
        end
        @(negedge clk);
        checks++;
        if ({ls, r0.cmd_ready, cs} !== 3'b000) begin
            failures++;
            $display("FAIL wake_n1: ls/rdy/cs=%b required 000", {ls, r0.cmd_ready, cs});
        end
        @(negedge clk);
        checks++;
        if (r0.cmd_ready !== 1'b1 || cs !== 1'b1 || addr !== 14'h10) begin
            failures++;
            $display("FAIL wake_n2_grant: rdy=%b cs=%b addr=%h required 1/1/0010", r0.cmd_ready,
                     cs, addr);
        end
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wake_n3_rsp: valid=%b rdata=%h required 1/deadbeef", r0.rsp_valid,
                     r0.rsp_rdata);
        end
    endtask

    task automatic test_reset_stall();
        @(posedge clk); #1;
        set_cmd(0, 1'b1, 1'b1, 14'h5, '0, '0);
        r0.rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (r0.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_stall_grant: got %b required 1", r0.cmd_ready);
        end
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 32'h11BB_33DD) begin
            failures++;
            $display("FAIL rst_stall_rsp: valid=%b rdata=%h required 1/11bb33dd", r0.rsp_valid,
                     r0.rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({r0.rsp_valid, r1.rsp_valid, ls, cs} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_stall_clear: rsp0/rsp1/ls/cs=%b required 0000",
                     {r0.rsp_valid, r1.rsp_valid, ls, cs});
        end
        @(posedge clk); #1;
        set_cmd(0, 1'b1, 1'b0, 14'h40, 32'h0000_0001, 4'hF);
        set_cmd(1, 1'b1, 1'b0, 14'h41, 32'h0000_0002, 4'hF);
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({r1.cmd_ready, r0.cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rst_ptr_grant: got %b required 01", {r1.cmd_ready, r0.cmd_ready});
        end
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (r0.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_ptr_rsp: got %b required 1", r0.rsp_valid);
        end
    endtask

    initial begin
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        r0.rsp_ready = 1'b0;
        r1.rsp_ready = 1'b0;
        test_reset();
        test_contention();
        test_single_read();
        test_partial_write();
        test_backpressure();
        test_sleep_wake();
        test_reset_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/e203_dtcm_ram_ctrl.md
# e203_dtcm_ram_ctrl

Two-port arbiter and sequencer for the DTCM SRAM macro. It shares one single-port DTCM RAM between the core LSU (requester 0) and the external ICB slave path (requester 1) with round-robin arbitration. It absorbs the macro's one-cycle read latency behind a valid/ready response handshake. It drives light-sleep entry and exit. It sits between the two requesters and the DTCM RAM ports of the SRAM wrapper.

## Interface
Parameters:
- AW, 14: DTCM RAM word address width.
- DW, 32: data width.
- MW, 4: write byte-mask width (DW/8).
- IDLE_LS_CYC, 16: idle cycles before light sleep. Minimum 2, maximum 255.

Ports:
- clk_dtcm_ram, in, 1: DTCM clock. This is the only clock.
- rst_dtcm, in, 1: reset, synchronous, active-high.
- reqN_cmd_valid, in, 1 (N = 0, 1): command valid.
- reqN_cmd_ready, out, 1: command accepted this cycle.
- reqN_cmd_read, in, 1: 1 = read, 0 = write.
- reqN_cmd_addr, in, AW: word address.
- reqN_cmd_wdata, in, DW: write data.
- reqN_cmd_wmask, in, MW: byte enables.
- reqN_rsp_valid, out, 1: response valid.
- reqN_rsp_ready, in, 1: response accepted.
- reqN_rsp_rdata, out, DW: read data. It is 0 for writes.
- dtcm_ram_cs, out, 1: SRAM chip select.
- dtcm_ram_we, out, 1: SRAM write enable.
- dtcm_ram_addr, out, AW: SRAM address.
- dtcm_ram_wem, out, MW: SRAM write mask.
- dtcm_ram_din, out, DW: SRAM write data.
- dtcm_ram_dout, in, DW: SRAM read data, valid one cycle after cs with we = 0.
- dtcm_ram_ls, out, 1: light sleep.
- dtcm_ram_ds, out, 1: deep sleep, tied 0.
- dtcm_ram_sd, out, 1: shutdown, tied 0.

## Operation
- **States:** ACTIVE, SLEEP, WAKE.
- **ACTIVE:**
  - A command is eligible when no response is outstanding, or when the outstanding response is accepted this cycle.
  - Round-robin between requesters. If both are valid, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins first.
  - Grant: cmd_ready = 1 for the winner only.
  - In the grant cycle the granted fields are driven to the RAM combinationally: cs = 1, we = ~read, addr, wem = wmask, din = wdata. With we = 0, wem and din are 0.
  - When not granting: cs = 0, we = 0, and addr/wem/din hold their previous values.
- **Response tracking:** one response may be outstanding. Record `rsp_owner` and `rsp_is_read`.
  - Cycle after grant: rsp_valid = 1 to the owner. rdata = dtcm_ram_dout for a read, 0 for a write.
  - If rsp_ready = 0 in that cycle, capture dout into a holding register. rdata then comes from the holding register until accepted.
- **Idle counter (8-bit):**
  - Cleared on any cs or outstanding response.
  - Otherwise increments, saturating at IDLE_LS_CYC.
  - Reaching IDLE_LS_CYC in ACTIVE moves to SLEEP.
- **SLEEP:**
  - dtcm_ram_ls = 1, cs = 0, all cmd_ready = 0.
  - Any cmd_valid moves to WAKE.
- **WAKE:**
  - ls = 0, cs = 0, cmd_ready = 0.
  - Next cycle returns to ACTIVE, where normal arbitration applies.
- **Simultaneous events:**
  - Response accepted and new grant in the same cycle is allowed, giving full throughput.
  - A requester may win a grant in the same cycle its previous response is accepted.
- **Requester release:** a requester dropping cmd_valid without ready is legal. The arbiter re-evaluates every cycle.

## Timing
- **Reset values:** all outputs 0, state ACTIVE, pointer 1, idle counter 0, no outstanding response.
- **Reset mid-operation:** an outstanding response is discarded, and rsp_valid is 0 the next cycle.
- **Read latency, awake:** cmd handshake in cycle N, rsp_valid in cycle N+1.
- **Wake from SLEEP:** cmd_valid in cycle N, WAKE in N+1, grant in N+2, response in N+3.
- **Throughput:** one access per cycle when rsp_ready is held high. Zero grants while a response is stalled.
- **Sleep entry:** ls asserts the cycle after the idle counter reaches IDLE_LS_CYC, i.e. IDLE_LS_CYC+1 idle cycles after the last response handshake.

## Structure
- Package e203_dtcm_ctrl_pkg holds:
  - state enum {ACTIVE, SLEEP, WAKE};
  - requester index type;
  - IDLE counter width constant (8).
- Sub-module e203_rr_arb2: two-way round-robin arbiter with valid inputs, grant one-hot output, and pointer update on an advance strobe.

## Test plan
- **Single read:** write 0xDEADBEEF to address 0x10 with mask 0xF via req0, then read 0x10 via req0. Required: rsp_rdata = 0xDEADBEEF in the cycle after the read grant.
- **Contention:** req0 and req1 held valid for 4 cycles with rsp_ready = 1. Required: grants alternate 0, 1, 0, 1 and cs is high in all 4 cycles.
- **Backpressure:** req1 reads 0x20 with rsp_ready = 0 for 3 cycles. Required:
  - rdata stays constant at the stored value;
  - no cmd_ready to either requester until the handshake;
  - a new grant occurs in the handshake cycle.
- **Partial write:** write 0x11223344 to 0x5, then write 0xAABBCCDD with mask 0b0101. Required: a read of 0x5 returns 0x11BB33DD.
- **Sleep and wake:** idle for IDLE_LS_CYC+1 cycles until ls = 1, then assert req0 read. Required:
  - ls falls the next cycle;
  - grant 2 cycles after cmd_valid;
  - response 3 cycles after cmd_valid.
- **Reset during a stalled response:** Required: rsp_valid = 0, ls = 0, and the next contention grants req0 first.
